// File: rtl/dpcm_sat_apb_mc.sv
// fifo_sync: generic synchronous FIFO with flush and occupancy count.
// Latency: a pushed entry is visible at out_dat the cycle after in_vld; pop retires the head on the same edge.
// Backpressure: none internal; pushes while full and pops while empty are ignored, caller checks full/empty.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   flush,
  input  logic                   in_vld,
  input  logic [WIDTH-1:0]       in_dat,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       out_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign out_dat = mem[rd_ptr];
  assign do_push = in_vld && !full;
  assign do_pop  = out_rdy && !empty;

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= in_dat;
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// dpcm_sat_apb_mc: multi-channel saturating DPCM encoder behind an APB slave, residuals queued for readback.
// Latency: register accesses zero-wait; SAMPLE writes take one wait state; residual readable the cycle after completion.
// Backpressure: SAMPLE write to a full FIFO completes with PSLVERR (sticky overflow); DOUT read when empty errors likewise.
// Ports: APB slave (PCLK, PRESETn, PSELx, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR), irq level output.
module dpcm_sat_apb_mc #(
  parameter int DATA_W     = 16,
  parameter int NCH        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);
  localparam int FW = DATA_W + 3;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} apb_state_t;
  apb_state_t state;

  logic                     en, ie, ovf, udf;
  logic [DATA_W-2:0]        sat_lim;
  logic [15:0]              sat_cnt;
  // Sized for the 3-bit channel field so any address-derived index is in range.
  logic signed [DATA_W-1:0] pred [8];

  logic        is_ctrl, is_status, is_satlim, is_dout, is_sample;
  logic        sample_wr, err_c, complete, ok;
  logic [2:0]  ch_sel;
  logic [31:0] rdata_c;

  logic          f_push, f_pop, f_clr, f_full, f_empty;
  logic [FW-1:0] f_head;
  logic [CW-1:0] f_count;

  logic signed [DATA_W-1:0] smp, pcur, pred_next, head_diff;
  logic signed [DATA_W:0]   diff, lim, clamped;
  logic                     sat_hit;
  logic [23:0]              head_diff24;
  logic                     unused_bits;

  assign ch_sel    = PADDR[4:2];
  assign is_ctrl   = (PADDR == 32'h0000_0000);
  assign is_status = (PADDR == 32'h0000_0004);
  assign is_satlim = (PADDR == 32'h0000_0008);
  assign is_dout   = (PADDR == 32'h0000_000C);
  assign is_sample = (PADDR[31:9] == 23'd0) && PADDR[8] && (PADDR[7:5] == 3'd0) &&
                     (PADDR[1:0] == 2'd0) && (int'(ch_sel) < NCH);
  assign sample_wr = PWRITE && is_sample;

  // Full-FIFO only errors when encoding is enabled; disabled SAMPLE writes are silent no-ops.
  assign err_c = !(is_ctrl || is_status || is_satlim || is_dout || is_sample) ||
                 (PWRITE && (is_status || is_dout)) ||
                 (!PWRITE && is_sample) ||
                 (sample_wr && en && f_full) ||
                 (!PWRITE && is_dout && f_empty);

  assign head_diff   = f_head[DATA_W-1:0];
  assign head_diff24 = 24'(head_diff);

  always_comb begin
    rdata_c = '0;
    if (is_ctrl)        rdata_c = {30'd0, ie, en};
    else if (is_status) rdata_c = {sat_cnt, 6'd0, udf, ovf, 1'b0, 7'(f_count)};
    else if (is_satlim) rdata_c = 32'(sat_lim);
    else if (is_dout)   rdata_c = {5'd0, f_head[FW-1:DATA_W], head_diff24};
  end

  // Residual at DATA_W+1 bits so the subtraction cannot wrap before clamping.
  assign smp  = PWDATA[DATA_W-1:0];
  assign pcur = pred[ch_sel];
  assign diff = {smp[DATA_W-1], smp} - {pcur[DATA_W-1], pcur};
  assign lim  = {2'b00, sat_lim};

  always_comb begin
    clamped = diff;
    sat_hit = 1'b0;
    if (diff > lim) begin
      clamped = lim;
      sat_hit = 1'b1;
    end else if (diff < -lim) begin
      clamped = -lim;
      sat_hit = 1'b1;
    end
  end

  // Clamp keeps the new prediction between old prediction and sample, so it always fits DATA_W.
  assign pred_next = pcur + clamped[DATA_W-1:0];

  // PREADY/PSLVERR/PRDATA are registered: the response is decided on the SETUP edge
  // (or on the wait-state edge for SAMPLE writes) and shown only for the completing cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      PREADY  <= 1'b1;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else if (PSELx && !PENABLE) begin
      if (sample_wr) begin
        state   <= S_WAIT;
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
        PRDATA  <= '0;
      end else begin
        state   <= S_DONE;
        PREADY  <= 1'b1;
        PSLVERR <= err_c;
        PRDATA  <= (!PWRITE && !err_c) ? rdata_c : '0;
      end
    end else if ((state == S_WAIT) && PSELx && PENABLE) begin
      state   <= S_DONE;
      PREADY  <= 1'b1;
      PSLVERR <= err_c;
      PRDATA  <= '0;
    end else begin
      // Covers completion, idle, and PSELx dropping mid wait state (abort).
      state   <= S_IDLE;
      PREADY  <= 1'b1;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end
  end

  assign complete = (state == S_DONE) && PSELx && PENABLE;
  assign ok       = complete && !PSLVERR;
  assign f_push   = ok && sample_wr && en;
  assign f_pop    = ok && !PWRITE && is_dout;
  assign f_clr    = ok && PWRITE && is_ctrl && PWDATA[2];

  fifo_sync #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .flush   (f_clr),
    .in_vld  (f_push),
    .in_dat  ({ch_sel, clamped[DATA_W-1:0]}),
    .out_rdy (f_pop),
    .out_dat (f_head),
    .count   (f_count),
    .full    (f_full),
    .empty   (f_empty)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      sat_cnt <= '0;
      sat_lim <= '1;
      for (int i = 0; i < 8; i++) pred[i] <= '0;
    end else begin
      if (ok && PWRITE && is_ctrl) begin
        en <= PWDATA[0];
        ie <= PWDATA[1];
      end
      if (ok && PWRITE && is_satlim) sat_lim <= PWDATA[DATA_W-2:0];
      if (f_push) begin
        pred[ch_sel] <= pred_next;
        if (sat_hit && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
      end
      if (complete && PSLVERR && sample_wr)          ovf <= 1'b1;
      if (complete && PSLVERR && !PWRITE && is_dout) udf <= 1'b1;
      if (f_clr) begin
        ovf     <= 1'b0;
        udf     <= 1'b0;
        sat_cnt <= '0;
        for (int i = 0; i < 8; i++) pred[i] <= '0;
      end
    end
  end

  assign irq = ie && !f_empty;

  assign unused_bits = ^{PWDATA[31:DATA_W], clamped[DATA_W]};
endmodule

// File: tb/tb_dpcm_sat_apb_mc.sv
module tb_dpcm_sat_apb_mc;
  localparam int DATA_W     = 16;
  localparam int NCH        = 4;
  localparam int FIFO_DEPTH = 8;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b1;
  logic        PSELx   = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PADDR   = '0;
  logic [31:0] PWDATA  = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq;

  dpcm_sat_apb_mc #(.DATA_W(DATA_W), .NCH(NCH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state; the scoreboard queue doubles as the model FIFO.
  int          pred_m [NCH];
  int          sat_lim_m;
  int          sat_m;
  bit          en_m, ie_m, ovf_m, udf_m;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    en_m = 0; ie_m = 0; ovf_m = 0; udf_m = 0;
    sat_m = 0; sat_lim_m = 32767;
    for (int i = 0; i < NCH; i++) pred_m[i] = 0;
    sb.delete();
  endtask

  task automatic model_clr();
    ovf_m = 0; udf_m = 0; sat_m = 0;
    for (int i = 0; i < NCH; i++) pred_m[i] = 0;
    sb.delete();
  endtask

  function automatic logic [31:0] status_exp();
    logic [15:0] s;
    logic [6:0]  c;
    s = 16'(sat_m);
    c = 7'(sb.size());
    return {s, 6'd0, udf_m, ovf_m, 1'b0, c};
  endfunction

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output logic err, output int waits);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdat;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (!PREADY && waits < 16) begin
      waits++;
      @(negedge PCLK);
    end
    if (!PREADY) chk("pready_timeout", PREADY, 1'b1);
    rdat = PRDATA;
    err  = PSLVERR;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic reg_wr(input string tag, input logic [31:0] addr, input logic [31:0] d, input logic exp_err);
    logic [31:0] rd; logic err; int w;
    apb_xfer(1'b1, addr, d, rd, err, w);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_wait"}, w, 0);
    if (!exp_err && addr == 32'h0) begin
      en_m = d[0]; ie_m = d[1];
      if (d[2]) model_clr();
    end
    if (!exp_err && addr == 32'h8) sat_lim_m = int'(d[14:0]);
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp, input logic exp_err);
    logic [31:0] rd; logic err; int w;
    apb_xfer(1'b0, addr, 32'h0, rd, err, w);
    chk({tag, "_err"}, err, exp_err);
    chk(tag, rd, exp_err ? 32'h0 : exp);
  endtask

  task automatic sample_wr(input int ch, input int val);
    logic [31:0] rd; logic err; int w; bit full; int d;
    logic [31:0] dv; logic [7:0] cb;
    full = (sb.size() == FIFO_DEPTH);
    apb_xfer(1'b1, 32'h100 + 32'(4 * ch), 32'(val), rd, err, w);
    chk("smp_err", err, en_m && full);
    chk("smp_wait", w, 1);
    if (en_m) begin
      if (full) ovf_m = 1;
      else begin
        d = val - pred_m[ch];
        if (d > sat_lim_m) begin
          d = sat_lim_m;
          if (sat_m < 65535) sat_m++;
        end else if (d < -sat_lim_m) begin
          d = -sat_lim_m;
          if (sat_m < 65535) sat_m++;
        end
        pred_m[ch] += d;
        dv = 32'(d);
        cb = 8'(ch);
        sb.push_back({cb, dv[23:0]});
      end
    end
  endtask

  task automatic dout_rd();
    logic [31:0] rd; logic err; int w; logic [31:0] e;
    apb_xfer(1'b0, 32'hC, 32'h0, rd, err, w);
    if (sb.size() == 0) begin
      chk("dout_empty_err", err, 1'b1);
      chk("dout_empty_dat", rd, 32'h0);
      udf_m = 1;
    end else begin
      e = sb.pop_front();
      chk("dout_err", err, 1'b0);
      chk("dout_dat", rd, e);
    end
  endtask

  task automatic chk_irq(input string tag);
    @(negedge PCLK);
    chk(tag, irq, ie_m && (sb.size() > 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 PRESETn = 1'b0;
    #2;
    chk("rst_pready", PREADY, 1'b1);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_irq", irq, 1'b0);
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    reg_rd("rst_ctrl", 32'h0, 32'h0, 1'b0);
    reg_rd("rst_status", 32'h4, 32'h0, 1'b0);
    reg_rd("rst_satlim", 32'h8, 32'h0000_7FFF, 1'b0);

    // Basic encode with one saturating step.
    reg_wr("ctrl_en", 32'h0, 32'h1, 1'b0);
    reg_wr("satlim", 32'h8, 32'd100, 1'b0);
    reg_rd("satlim_rb", 32'h8, 32'd100, 1'b0);
    sample_wr(0, 50);
    sample_wr(0, 120);
    sample_wr(0, 400);
    reg_rd("status3", 32'h4, status_exp(), 1'b0);
    chk_irq("irq_ie0");
    reg_wr("ctrl_ie", 32'h0, 32'h3, 1'b0);
    chk_irq("irq_ie1");
    repeat (3) dout_rd();
    chk_irq("irq_drained");
    sample_wr(0, 220);
    dout_rd();

    // Interleaved channels, negative residuals.
    sample_wr(1, -30);
    sample_wr(2, 10);
    sample_wr(1, -40);
    repeat (3) dout_rd();

    // Overflow then underflow.
    for (int i = 0; i < 9; i++) sample_wr(3, i * 5);
    reg_rd("status_full", 32'h4, status_exp(), 1'b0);
    for (int i = 0; i < 9; i++) dout_rd();
    reg_rd("status_udf", 32'h4, status_exp(), 1'b0);

    // Address errors with no side effects.
    reg_wr("wr_unmapped", 32'h200, 32'hFFFF_FFFF, 1'b1);
    reg_rd("rd_sample", 32'h100, 32'h0, 1'b1);
    reg_wr("wr_status", 32'h4, 32'hFFFF_FFFF, 1'b1);
    reg_wr("wr_dout", 32'hC, 32'h1, 1'b1);
    reg_wr("wr_ch_oor", 32'h110, 32'h5, 1'b1);
    reg_rd("rd_misalign", 32'h2, 32'h0, 1'b1);
    reg_rd("ctrl_kept", 32'h0, 32'h3, 1'b0);
    reg_rd("satlim_kept", 32'h8, 32'd100, 1'b0);
    reg_rd("status_kept", 32'h4, status_exp(), 1'b0);

    // PSELx dropped during the SAMPLE wait state aborts the write.
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h108; PWDATA = 32'd999;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_wait_rdy", PREADY, 1'b0);
    #1 PSELx = 1'b0; PENABLE = 1'b0;
    reg_rd("abort_status", 32'h4, status_exp(), 1'b0);

    // Disabled encoder: SAMPLE write is a silent no-op.
    reg_wr("ctrl_dis", 32'h0, 32'h2, 1'b0);
    sample_wr(0, 1234);
    reg_rd("dis_status", 32'h4, status_exp(), 1'b0);
    reg_wr("ctrl_reen", 32'h0, 32'h3, 1'b0);
    sample_wr(0, 250);
    chk_irq("irq_reen");
    dout_rd();

    // Clear after three samples.
    sample_wr(1, 500);
    sample_wr(2, 20);
    sample_wr(0, 260);
    reg_rd("pre_clr_status", 32'h4, status_exp(), 1'b0);
    reg_wr("ctrl_clr", 32'h0, 32'h7, 1'b0);
    reg_rd("clr_status", 32'h4, status_exp(), 1'b0);
    chk_irq("irq_after_clr");
    reg_rd("clr_satlim", 32'h8, 32'd100, 1'b0);
    reg_rd("clr_ctrl", 32'h0, 32'h3, 1'b0);
    sample_wr(1, 30);
    dout_rd();

    // Reset asserted in the middle of a SAMPLE wait state.
    sample_wr(0, 5);
    chk_irq("irq_pre_rst");
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h104; PWDATA = 32'd77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("rstw_wait_rdy", PREADY, 1'b0);
    #1 PRESETn = 1'b0;
    #1;
    chk("rstw_pready", PREADY, 1'b1);
    chk("rstw_pslverr", PSLVERR, 1'b0);
    chk("rstw_prdata", PRDATA, 32'h0);
    chk("rstw_irq", irq, 1'b0);
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    model_reset();
    dout_rd();
    reg_rd("rstw_satlim", 32'h8, 32'h0000_7FFF, 1'b0);
    reg_rd("rstw_ctrl", 32'h0, 32'h0, 1'b0);
    reg_rd("rstw_status", 32'h4, status_exp(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dpcm_sat_apb_mc.md
DPCM_SAT_APB_MC -- requirements
Module: dpcm_sat_apb_mc

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16, meaning sample width in bits, signed two's complement, legal range 8..24.
REQ-002 The block SHALL take parameter NCH, default 4, meaning independent DPCM channel count, legal range 1..8.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 8, meaning output FIFO entries, power of two, 2..64.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low (PCLK, PRESETn).
REQ-005 Ports: PCLK in 1 APB clock; PRESETn in 1 async active-low reset; PSELx in 1 slave select; PENABLE in 1 access phase; PWRITE in 1 write strobe; PADDR in 32 byte address; PWDATA in 32 write data.
REQ-006 Ports: PRDATA out 32 read data; PREADY out 1 transfer complete; PSLVERR out 1 transfer error; irq out 1 level interrupt, high when FIFO non-empty and CTRL.ie=1.

Function
REQ-007 Register map SHALL be: 0x00 CTRL rw (bit0 en, bit1 ie, bit2 clr self-clearing); 0x04 STATUS ro (bits[6:0] fifo count, bit8 overflow sticky, bit9 underflow sticky, bits[31:16] saturation event count); 0x08 SAT_LIM rw (unsigned, DATA_W-1 bits); 0x0C DOUT ro pop; 0x100+4*ch SAMPLE wo, ch<NCH.
REQ-008 APB SHALL follow IDLE -> SETUP (PSELx & !PENABLE) -> ACCESS (PSELx & PENABLE); transfer completes in the ACCESS cycle where PREADY=1.
REQ-009 Register accesses SHALL be zero-wait (PREADY=1 in first ACCESS cycle); SAMPLE writes SHALL insert exactly one wait state (PREADY=0 first ACCESS cycle, 1 second).
REQ-010 PSLVERR SHALL be asserted only in the completing ACCESS cycle, for: unmapped address, write to ro register, read of SAMPLE, SAMPLE write with FIFO full, DOUT read with FIFO empty.
REQ-011 Erroring transfers SHALL have no side effect except setting the overflow (full write) or underflow (empty read) sticky bit.
REQ-012 SAMPLE write to ch: diff = PWDATA[DATA_W-1:0] - pred[ch], computed at DATA_W+1 bits, no wrap.
REQ-013 diff SHALL be clamped to [-SAT_LIM, +SAT_LIM]; each clamp SHALL increment saturation count, which holds at 0xFFFF.
REQ-014 Prediction SHALL be closed-loop: pred[ch] <= pred[ch] + clamped diff (never overflows DATA_W).
REQ-015 FIFO entry SHALL be {ch, clamped diff}; DOUT read returns PRDATA[31:24]=ch, PRDATA[23:0]=diff sign-extended, and pops one entry in the completing cycle.
REQ-016 With CTRL.en=0, SAMPLE writes SHALL complete without error and with no state change.
REQ-017 CTRL.clr=1 SHALL, in the same completing cycle, zero all pred[], empty FIFO, clear sticky bits and saturation count; SAT_LIM unaffected.
REQ-018 PRDATA SHALL be driven only in completing read cycles, else 0; unused register bits read 0.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL reach exactly FIFO_DEPTH when full.
REQ-020 PSELx deassertion mid-SAMPLE wait state SHALL abort the transfer with no state change.

Reset
REQ-021 On PRESETn=0, asynchronously: PREADY=1, PSLVERR=0, PRDATA=0, irq=0, CTRL=0, SAT_LIM=2^(DATA_W-1)-1, pred[]=0, FIFO empty, sticky bits and counters 0, APB FSM IDLE.
REQ-022 Reset asserted mid-transfer SHALL discard the transfer; first transfer after release behaves as from IDLE.

Verification
REQ-023 CTRL=1, SAT_LIM=100; write ch0 samples 50,120,400 -> DOUT 0x00000032, 0x00000046, 0x00000064; STATUS sat count 1; pred[0]=220.
REQ-024 Write ch1=-30, ch2=10 interleaved with ch1=-40 -> DOUT ch1 -30, ch2 10, ch1 -10 in order; PRDATA[31:24]=1,2,1.
REQ-025 FIFO_DEPTH=8: nine SAMPLE writes without reads -> ninth PSLVERR=1, STATUS count 8, overflow=1; nine DOUT reads -> ninth PSLVERR=1, underflow=1.
REQ-026 Write 0x200, read 0x100, write 0x04 -> each PSLVERR=1, registers unchanged; SAMPLE write shows PREADY=0 then 1.
REQ-027 Assert PRESETn=0 during SAMPLE wait state -> outputs at reset values immediately; next DOUT read errors (FIFO empty).
REQ-028 Write CTRL=0b111 after three samples -> FIFO empty, pred[]=0, irq=0, SAT_LIM retained.
